// File: rtl/ex_muldiv_unit_pkg.sv
// Shared opcodes, FSM encodings and constants for the execute-stage mul/div unit.
package ex_muldiv_unit_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    function automatic logic is_muldiv(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Magnitude of a two's-complement value; 0x80000000 maps to itself as an unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_muldiv_step.sv
// One radix-2 iteration on the 64-bit working pair: shift-add for multiply,
// restoring shift-subtract for divide.
module ex_muldiv_unit_muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     opb,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W-1:0] diff;

    always_comb begin
        acc_next = acc;
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        if (!is_div) begin
            // acc = {partial product, remaining multiplier bits}; carry lands in the top bit
            sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
            acc_next = {sum, acc[DATA_W-1:1]};
        end else begin
            rem_sh = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
            diff   = rem_sh[DATA_W-1:0] - opb;
            if (rem_sh >= {1'b0, opb})
                acc_next = {diff, acc[DATA_W-2:0], 1'b1};
            else
                acc_next = {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; stalls the pipeline while a mul/div runs.
//   state | meaning
//   IDLE  | waiting for a request; MTHI/MTLO serviced here
//   CALC  | one radix-2 step per cycle, count 0..ITERS-1
//   DONE  | result just committed to HI/LO, doneE high for this cycle
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITERS  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MD_OP_W-1:0]  mdOpE,
    input  logic                startE,
    input  logic                flushE,
    input  logic [DATA_W-1:0]   SrcA,
    input  logic [DATA_W-1:0]   SrcB,
    output logic                stallE,
    output logic                doneE,
    output logic [DATA_W-1:0]   hiE,
    output logic [DATA_W-1:0]   loE
);

    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    md_state_e           state;
    md_op_e              op;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc, step_next, prod_fix;
    logic [DATA_W-1:0]   opb, hi_q, lo_q, q_fix, r_fix, abs_a, abs_b;
    logic                op_div, neg_q, neg_r, div_zero, done_q;
    logic                start_ok, start_md, op_signed, op_is_div;

    assign op        = md_op_e'(mdOpE);
    assign start_ok  = startE && !flushE && (state != ST_CALC);
    assign start_md  = start_ok && is_muldiv(op);
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign abs_a     = abs32(SrcA, op_signed);
    assign abs_b     = abs32(SrcB, op_signed);

    assign stallE = start_md || (state == ST_CALC);
    assign doneE  = done_q;
    assign hiE    = hi_q;
    assign loE    = lo_q;

    ex_muldiv_unit_muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div   (op_div),
        .acc      (acc),
        .opb      (opb),
        .acc_next (step_next)
    );

    // Sign correction applied to the final iteration's output as it is written to HI/LO
    assign prod_fix = neg_q ? (~step_next + 1'b1) : step_next;
    assign q_fix    = neg_q ? (~step_next[DATA_W-1:0] + 1'b1) : step_next[DATA_W-1:0];
    assign r_fix    = neg_r ? (~step_next[2*DATA_W-1:DATA_W] + 1'b1) : step_next[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            acc      <= '0;
            opb      <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_CALC: begin
                    if (flushE) begin
                        state <= ST_IDLE;
                    end else begin
                        acc   <= step_next;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            if (op_div) begin
                                hi_q <= r_fix;
                                lo_q <= div_zero ? DIV_ZERO_QUOT : q_fix;
                            end else begin
                                hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                                lo_q <= prod_fix[DATA_W-1:0];
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (start_md) begin
                        state    <= ST_CALC;
                        count    <= '0;
                        op_div   <= op_is_div;
                        neg_q    <= op_signed && (SrcA[DATA_W-1] ^ SrcB[DATA_W-1]);
                        neg_r    <= op_signed && SrcA[DATA_W-1];
                        div_zero <= (SrcB == '0);
                        // Divide shifts the dividend out of the low half; multiply shifts the multiplier
                        acc      <= op_is_div ? {{DATA_W{1'b0}}, abs_a} : {{DATA_W{1'b0}}, abs_b};
                        opb      <= op_is_div ? abs_b : abs_a;
                    end else if (start_ok && op == MD_MTHI) begin
                        hi_q <= SrcA;
                    end else if (start_ok && op == MD_MTLO) begin
                        lo_q <= SrcA;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: behavioural HI/LO/latency model plus directed literal checks.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mdOpE;
    logic        startE, flushE;
    logic [31:0] SrcA, SrcB;
    logic        stallE, doneE;
    logic [31:0] hiE, loE;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .mdOpE  (mdOpE),
        .startE (startE),
        .flushE (flushE),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .stallE (stallE),
        .doneE  (doneE),
        .hiE    (hiE),
        .loE    (loE)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI,LO} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint   p;
        int       ia, ib;
        case (op)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                ia = a;
                ib = b;
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic bit op_is_md(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Behavioural model: busy window of 32 cycles after the accept, then a commit
    bit          m_busy, m_done;
    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_left <= 0;
            m_hi <= '0; m_lo <= '0; m_res <= '0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                if (flushE) begin
                    m_busy <= 0;
                end else if (m_left == 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (startE && !flushE) begin
                if (op_is_md(mdOpE)) begin
                    m_busy <= 1;
                    m_left <= 32;
                    m_res  <= ref_result(mdOpE, SrcA, SrcB);
                end else if (mdOpE == MD_MTHI) begin
                    m_hi <= SrcA;
                end else if (mdOpE == MD_MTLO) begin
                    m_lo <= SrcA;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("stallE", 64'(stallE), 64'(m_busy || (startE && !flushE && op_is_md(mdOpE))));
            check("doneE", 64'(doneE), 64'(m_done));
            check("hiE", 64'(hiE), 64'(m_hi));
            check("loE", 64'(loE), 64'(m_lo));
        end
    end

    // chain=1 drives the request in the current cycle (e.g. straight out of DONE)
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit chain, output int stalls, output bit done_seen);
        stalls    = 0;
        done_seen = 0;
        if (!chain) @(posedge clk);
        #1;
        startE = 1; mdOpE = op; SrcA = a; SrcB = b; flushE = 0;
        if (!chain) begin
            @(negedge clk);
            if (stallE) stalls++;
        end
        @(posedge clk); #1;
        startE = 0; mdOpE = MD_NONE; SrcA = $urandom; SrcB = $urandom;
        if (op_is_md(op)) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (stallE) stalls++;
                if (doneE) begin
                    done_seen = 1;
                    break;
                end
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "simulation time limit");
    end

    int  st;
    bit  dn;
    int  n_done;

    initial begin
        rst = 1; startE = 0; flushE = 0; mdOpE = 0; SrcA = 0; SrcB = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_hi", 64'(hiE), 64'h0);
        check("reset_lo", 64'(loE), 64'h0);
        check("reset_stall", 64'(stallE), 64'h0);
        check("reset_done", 64'(doneE), 64'h0);

        check("model_div_neg", ref_result(MD_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_mult_neg", ref_result(MD_MULT, 32'hFFFF_FFF9, 32'd3), 64'hFFFF_FFFF_FFFF_FFEB);

        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, st, dn);
        check("multu_stall_cycles", 64'(st), 64'd33);
        check("multu_done", 64'(dn), 64'd1);
        check("multu_hi", 64'(hiE), 64'hFFFF_FFFE);
        check("multu_lo", 64'(loE), 64'h0000_0001);

        do_op(MD_MULT, 32'hFFFF_FFF9, 32'd3, 1, st, dn);
        check("mult_done", 64'(dn), 64'd1);
        check("mult_hi", 64'(hiE), 64'hFFFF_FFFF);
        check("mult_lo", 64'(loE), 64'hFFFF_FFEB);

        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, st, dn);
        check("div_stall_cycles", 64'(st), 64'd33);
        check("div_hi", 64'(hiE), 64'hFFFF_FFFF);
        check("div_lo", 64'(loE), 64'hFFFF_FFFD);

        do_op(MD_DIVU, 32'd100, 32'd7, 0, st, dn);
        check("divu_hi", 64'(hiE), 64'd2);
        check("divu_lo", 64'(loE), 64'd14);

        do_op(MD_DIVU, 32'd5, 32'd0, 0, st, dn);
        check("divu0_stall_cycles", 64'(st), 64'd33);
        check("divu0_hi", 64'(hiE), 64'd5);
        check("divu0_lo", 64'(loE), 64'hFFFF_FFFF);

        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 0, st, dn);
        check("div0_hi", 64'(hiE), 64'hFFFF_FFF9);
        check("div0_lo", 64'(loE), 64'hFFFF_FFFF);

        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, st, dn);
        check("divovf_hi", 64'(hiE), 64'h0);
        check("divovf_lo", 64'(loE), 64'h8000_0000);

        do_op(MD_MTHI, 32'h1234_5678, 32'h0, 0, st, dn);
        check("mthi_stall", 64'(st), 64'd0);
        do_op(MD_MTLO, 32'h9ABC_DEF0, 32'h0, 1, st, dn);
        @(negedge clk);
        check("mt_hi", 64'(hiE), 64'h1234_5678);
        check("mt_lo", 64'(loE), 64'h9ABC_DEF0);

        // MTHI with flush in the same cycle is squashed
        @(posedge clk); #1;
        startE = 1; mdOpE = MD_MTHI; SrcA = 32'hDEAD_BEEF; flushE = 1;
        @(posedge clk); #1;
        startE = 0; mdOpE = MD_NONE; flushE = 0;
        @(negedge clk);
        check("flushed_mthi_hi", 64'(hiE), 64'h1234_5678);

        // DIVU flushed at t10
        @(posedge clk); #1;
        startE = 1; mdOpE = MD_DIVU; SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge clk); #1;
        startE = 0; mdOpE = MD_NONE;
        repeat (9) @(posedge clk);
        #1 flushE = 1;
        @(negedge clk);
        check("flush_t10_stall", 64'(stallE), 64'd1);
        @(posedge clk); #1 flushE = 0;
        @(negedge clk);
        check("flush_t11_stall", 64'(stallE), 64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (doneE) n_done++;
        end
        check("flush_no_done", 64'(n_done), 64'd0);
        check("flush_hi", 64'(hiE), 64'h1234_5678);
        check("flush_lo", 64'(loE), 64'h9ABC_DEF0);

        // Reset at t15 of a MULT
        @(posedge clk); #1;
        startE = 1; mdOpE = MD_MULT; SrcA = 32'd5; SrcB = 32'hFFFF_FFF7;
        @(posedge clk); #1;
        startE = 0; mdOpE = MD_NONE;
        repeat (14) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("rst_mid_stall", 64'(stallE), 64'd0);
        check("rst_mid_hi", 64'(hiE), 64'h0);
        check("rst_mid_lo", 64'(loE), 64'h0);
        do_op(MD_MULTU, 32'd3, 32'd4, 0, st, dn);
        check("post_rst_stall_cycles", 64'(st), 64'd33);
        check("post_rst_hi", 64'(hiE), 64'h0);
        check("post_rst_lo", 64'(loE), 64'd12);

        // Randomized mix; the per-cycle compare process checks every result
        for (int i = 0; i < 80; i++) begin
            logic [2:0] op;
            bit         chain;
            op    = 3'($urandom_range(0, 6));
            chain = dn && ($urandom_range(0, 1) == 1);
            do_op(op, pick(), pick(), chain, st, dn);
            if (op_is_md(op)) check("rand_done_seen", 64'(dn), 64'd1);
            else dn = 0;
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU. It is fed the same forwarded operands (SrcA, SrcB) and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over 32 iterations and holds the pipeline via a stall request while busy.
- Services MTHI/MTLO in a single cycle and exposes HI/LO to the writeback mux for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- ITERS, 32, iterations per mul/div; must equal DATA_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mdOpE  in  3  operation code (encoding under Decomposition); sampled only when startE=1.
- startE  in  1  request from the execute stage; qualifies mdOpE.
- flushE  in  1  squash of the current execute instruction; aborts any in-flight operation.
- SrcA  in  32  operand A (multiplicand / dividend / MTHI-MTLO source).
- SrcB  in  32  operand B (multiplier / divisor).
- stallE  out  1  stall request to the hazard unit.
- doneE  out  1  one-cycle pulse when a mul/div result has committed to HI/LO.
- hiE  out  32  current HI register.
- loE  out  32  current LO register.

Behaviour:
- Reset:
  - Sync, active-high: state=IDLE, HI=LO=0, count=0, stallE=0, doneE=0.
  - Reset mid-CALC discards the operation.
- FSM states: IDLE, CALC, DONE.
- IDLE or DONE with startE=1 and flushE=0:
  - MULT/MULTU/DIV/DIVU: latch |SrcA|, |SrcB| and the result signs (signed ops only), count=0, go to CALC.
  - MTHI: HI<=SrcA; stay in / return to IDLE; no stall.
  - MTLO: LO<=SrcA; same as MTHI.
  - NONE: no action.
- DONE without an accepted start: go to IDLE. DONE lasts exactly one cycle with doneE=1.
- CALC:
  - One radix-2 step per cycle, count increments.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 64-bit remainder:quotient pair.
  - When count==31, apply sign correction, write HI/LO at that edge, go to DONE.
- Latency, with the accept cycle as t0:
  - CALC occupies t1..t32.
  - New HI/LO are visible on hiE/loE from t33, when doneE=1.
- stallE = (accept of a mul/div this cycle) OR (state==CALC). It is high for t0..t32 (33 cycles), low in DONE, and combinational from startE/mdOpE/state.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
- Divide by zero (SrcB=0): same latency; LO=32'hFFFFFFFF, HI=SrcA unmodified. No exception.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- flushE=1:
  - In CALC: abort, go to IDLE next cycle, HI/LO unchanged, no doneE.
  - With startE in IDLE/DONE: the start is ignored, including MTHI/MTLO.
- startE while in CALC: ignored. The stalled pipeline re-presents the op; the bench must not rely on it.
- hiE/loE are always the registered HI/LO. There is no bypass of in-flight results; MFHI/MFLO correctness depends on stallE.

Decomposition:
- Shared package/header holds:
  - MD_OP width and codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - FSM state encodings.
  - The divide-by-zero quotient constant.
- One natural sub-module, muldiv_step: combinational single iteration (shift-add or shift-subtract on the 64-bit working pair, selected by a mul/div flag). Instantiated once inside the FSM datapath.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - stallE high for exactly 33 cycles.
  - doneE at t33 with HI=0xFFFFFFFE, LO=0x00000001.
- MULT −7 (0xFFFFFFF9) × 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI then MTLO back-to-back:
  - MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> HI/LO updated one cycle each, stallE never high.
  - Then DIVU with flushE pulsed at t10 -> IDLE at t11, HI/LO still 0x12345678/0x9ABCDEF0, no doneE.
- rst asserted at t15 of a MULT -> next cycle state IDLE, HI=LO=0, stallE=0. A following MULTU 3×4 gives LO=12 at t33.
